fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of each requester word and of the FIFO write data.
REQ-002 Parameter: NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter: MAX_BURST, default 4, maximum words per grant (1..16).
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: req  input  NUM_REQ  per-requester write request; bit i held high while requester i has a word.
REQ-007 Port: req_data  input  NUM_REQ*DATA_WIDTH  requester i word on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: ack  output  NUM_REQ  one-hot; bit i high = requester i's word is written this cycle.
REQ-009 Port: gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
REQ-010 Port: owner  output  3  registered index of current/last grant owner.
REQ-011 Port: fifo_full  input  1  full flag of the shared FIFO write port.
REQ-012 Port: fifo_wr_en  output  1  write enable to the shared FIFO.
REQ-013 Port: fifo_data_in  output  DATA_WIDTH  write data to the shared FIFO.

Function
REQ-014 Two states SHALL exist: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-015 IDLE -> GRANT when req!=0; the winner SHALL be the first set req bit scanning from (owner+1) mod NUM_REQ upward with wrap-around.
REQ-016 gnt and owner SHALL update at the edge leaving IDLE; the first transfer is possible in the first GRANT cycle (1-cycle request-to-grant latency).
REQ-017 fifo_wr_en SHALL be combinational: |(gnt & req) & !fifo_full; ack SHALL equal gnt & req when fifo_wr_en=1, else 0.
REQ-018 fifo_data_in SHALL be the req_data slice of the gnt owner; it SHALL be zero in IDLE.
REQ-019 A burst counter (5 bits) SHALL clear on grant and increment on each cycle with fifo_wr_en=1.
REQ-020 GRANT -> IDLE on the edge where req[owner]=0, or where a transfer makes the counter equal MAX_BURST; one idle bubble cycle always follows a release.
REQ-021 fifo_full=1 in GRANT: grant SHALL be held, no ack, counter unchanged; no timeout.
REQ-022 Requests of non-owners SHALL be ignored until re-arbitration; no requester SHALL be granted twice in a row while another requests at release time.
REQ-023 Requester i SHALL keep req_data stable until ack[i]; dropping req[owner] with ack=0 SHALL release without a write.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, gnt=0, owner=NUM_REQ-1 (req 0 highest priority next), counter=0.
REQ-025 During reset and the cycle after, fifo_wr_en=0, ack=0 and fifo_data_in=0.
REQ-026 Reset mid-burst SHALL abandon the burst with no partial write on the reset cycle.

Configuration
REQ-027 Macro FIFO_ARB_BURST_EN defined: bursts up to MAX_BURST words per grant as in REQ-019..REQ-020.
REQ-028 Macro FIFO_ARB_BURST_EN undefined: the counter SHALL be omitted and every grant released after exactly one transfer (MAX_BURST treated as 1).

Verification
REQ-029 After reset, req=4'b0101 held, fifo_full=0 -> grants in order 0,2,0,2 with one idle cycle between each.
REQ-030 BURST_EN, req=4'b0001 held, data 8'hA0..8'hA5 -> 4 writes A0..A3, one idle cycle, then A4,A5 in next grant.
REQ-031 Owner 1 granted, fifo_full=1 for 3 cycles -> gnt=4'b0010 held, fifo_wr_en=0, ack=0; transfer on first cycle fifo_full=0.
REQ-032 Owner 3 mid-burst after 2 writes, rst=1 one cycle -> next cycle gnt=0, fifo_wr_en=0; req=4'b1001 then grants 0 first.
REQ-033 Without BURST_EN, req=4'b1111 held 12 cycles -> one write per grant in order 0,1,2,3,0,1, each owner's ack exactly one cycle.
REQ-034 Owner 2 drops req before any ack -> release, no fifo_wr_en pulse, next grant to lowest set req above 2 with wrap.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter granting one requester at a time write
//             access to a shared FIFO port. Define FIFO_ARB_BURST_EN for
//             multi-word bursts of up to MAX_BURST words per grant.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [2:0]                    owner,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0   = NUM_REQ'(1);
  localparam logic [2:0]         OWNER_RESET = 3'(NUM_REQ - 1);

  // Out-of-range parameters leave a marker scope in the elaborated hierarchy.
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_param_range_err
  end

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]           owner_q, owner_d;

  logic                 w_owner_req;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_found;
  logic [2:0]           w_win;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_owner_req = |(gnt_q & req);
  // A write on the reset cycle would be a partial burst write, so rst gates it.
  assign w_xfer      = (state_q == ST_GRANT) && w_owner_req && !fifo_full && !rst;

  // Round-robin search starting just above the last owner.
  always_comb begin
    int unsigned idx;
    w_found   = 1'b0;
    w_win     = '0;
    w_req_rot = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx       = (int'(owner_q) + k) % NUM_REQ;
      w_req_rot = req >> idx;
      if (!w_found && w_req_rot[0]) begin
        w_found = 1'b1;
        w_win   = 3'(idx);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

  logic [4:0] cnt_q, cnt_d;

  assign w_last = (cnt_q + 5'd1) == BURST_LIMIT;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && w_found) begin
      cnt_d = '0;
    end else if (w_xfer) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign w_last = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          state_d = ST_GRANT;
          gnt_d   = ONE_HOT_0 << w_win;
          owner_d = w_win;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req || (w_xfer && w_last)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= OWNER_RESET;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

  // gnt_q is zero when idle, so the OR-mux naturally yields zero data there.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign fifo_wr_en   = w_xfer;
  assign ack          = w_xfer ? (gnt_q & req) : '0;
  assign fifo_data_in = rst ? '0 : w_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed self-checking bench for fifo_wr_arbiter (4 x 8-bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] dv [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  int seq_a [4] = '{0, 2, 0, 2};
  int seq_b [6] = '{0, 1, 2, 3, 0, 1};

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .gnt          (gnt),
    .owner        (owner),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int own);
    chk({tag, "_gnt"},   32'(gnt),          32'(1) << own);
    chk({tag, "_owner"}, 32'(owner),        32'(own));
    chk({tag, "_wr_en"}, 32'(fifo_wr_en),   32'd1);
    chk({tag, "_ack"},   32'(ack),          32'(1) << own);
    chk({tag, "_data"},  32'(fifo_data_in), 32'(dv[own]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},   32'(gnt),          32'd0);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en),   32'd0);
    chk({tag, "_ack"},   32'(ack),          32'd0);
    chk({tag, "_data"},  32'(fifo_data_in), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    req_data  = {dv[3], dv[2], dv[1], dv[0]};
    step();
    step();

    // Reset state, including requests present while rst is high
    chk_idle("rst");
    chk("rst_owner", 32'(owner), 32'd3);
    req = 4'b1111;
    #1;
    chk_idle("rst_req");
    step();

    // Alternating requesters 0 and 2, one bubble between grants
    rst = 1'b0;
    req = 4'b0101;
    #1;
    chk_idle("pre_alt");
    for (int g = 0; g < 4; g++) begin
      for (int w = 0; w < BL; w++) begin
        step();
        chk_grant("alt", seq_a[g]);
      end
      step();
      chk_idle("alt_bubble");
    end

    // Owner 1 stalled by fifo_full for three cycles
    req       = 4'b0010;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      else step();
      chk("full_gnt",   32'(gnt),        32'h2);
      chk("full_owner", 32'(owner),      32'd1);
      chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("full_ack",   32'(ack),        32'd0);
    end
    fifo_full = 1'b0;
    #1;
    chk_grant("unfull", 1);
    step();
    req = 4'b0000;
    #1;
    chk("drop_wr_en", 32'(fifo_wr_en), 32'd0);
    step();
    chk_idle("full_release");

    // Owner 2 drops its request before any ack; next winner wraps to 0
    req       = 4'b0100;
    fifo_full = 1'b1;
    step();
    chk("own2_gnt",   32'(gnt),        32'h4);
    chk("own2_owner", 32'(owner),      32'd2);
    req       = 4'b0011;
    fifo_full = 1'b0;
    #1;
    chk("own2_drop_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("own2_drop_ack",   32'(ack),        32'd0);
    step();
    chk_idle("own2_release");
    step();
    chk_grant("wrap", 0);
    step();
    req = 4'b0000;
    #1;
    step();
    chk_idle("wrap_release");

    // Reset while owner 3 is mid-burst
    req = 4'b1000;
    step();
    chk_grant("own3_w1", 3);
`ifdef FIFO_ARB_BURST_EN
    step();
    chk_grant("own3_w2", 3);
    step();
    chk("own3_hold_gnt", 32'(gnt), 32'h8);
`endif
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(fifo_wr_en),   32'd0);
    chk("midrst_ack",   32'(ack),          32'd0);
    chk("midrst_data",  32'(fifo_data_in), 32'd0);
    step();
    rst = 1'b0;
    req = 4'b1001;
    #1;
    chk_idle("post_rst");
    chk("post_rst_owner", 32'(owner), 32'd3);
    step();
    chk_grant("post_rst", 0);
    req = 4'b0000;
    #1;
    step();
    chk_idle("post_rst_release");

    // All four requesting continuously: strict rotation
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      for (int w = 0; w < BL; w++) begin
        step();
        chk_grant("rr", seq_b[g]);
      end
      step();
      chk_idle("rr_bubble");
    end
    req = 4'b0000;
    step();

`ifdef FIFO_ARB_BURST_EN
    // Six-word stream from requester 0 splits into 4 + 2 with one bubble
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0001;
    req_data[7:0] = 8'hA0;
    step();
    for (int w = 0; w < 4; w++) begin
      chk("burst_wr_en", 32'(fifo_wr_en),   32'd1);
      chk("burst_data",  32'(fifo_data_in), 32'(8'hA0) + 32'(w));
      step();
      req_data[7:0] = 8'(8'hA0 + w + 1);
      #1;
    end
    chk_idle("burst_bubble");
    step();
    chk("burst_a4", 32'(fifo_data_in), 32'hA4);
    step();
    req_data[7:0] = 8'hA5;
    #1;
    chk("burst_a5",       32'(fifo_data_in), 32'hA5);
    chk("burst_a5_wr_en", 32'(fifo_wr_en),   32'd1);
    step();
    req = 4'b0000;
    step();
    chk_idle("burst_end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
